// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, scan-code constants and key map for the PS/2 receiver
package ps2_pkg;

  localparam int EN_W = 5;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_KEY0  = 8'h16;
  localparam logic [7:0] SC_KEY1  = 8'h1E;
  localparam logic [7:0] SC_KEY2  = 8'h26;
  localparam logic [7:0] SC_KEY3  = 8'h25;
  localparam logic [7:0] SC_ALARM = 8'h1C;

  // Zero means the scan code is not one of the mapped set keys.
  function automatic logic [EN_W-1:0] key_onehot(input logic [7:0] sc);
    logic [EN_W-1:0] oh;
    case (sc)
      SC_KEY0:  oh = 5'b00001;
      SC_KEY1:  oh = 5'b00010;
      SC_KEY2:  oh = 5'b00100;
      SC_KEY3:  oh = 5'b01000;
      SC_ALARM: oh = 5'b10000;
      default:  oh = 5'b00000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/ps2_filtro.sv
// rtl/ps2_filtro.sv - synchronizer, glitch filter and falling-edge strobe for ps2_clk
module ps2_filtro #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  // The filtered level only flips after FILTER_LEN consecutive differing samples.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      filt_q <= 1'b0;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      fall_q <= fall_d;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/receptor_ps2_teclado.sv
// rtl/receptor_ps2_teclado.sv - PS/2 frame receiver with make/break tracking of the set keys
module receptor_ps2_teclado
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  output logic [EN_W-1:0] enable,
  output logic [7:0]      scan_code,
  output logic            code_valid,
  output logic            frame_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic            fall;
  logic [1:0]      dsync_q;
  ps2_state_e      state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            brk_q, brk_d, ext_q, ext_d;
  logic [EN_W-1:0] enable_q, enable_d, key;
  logic [7:0]      scan_q, scan_d;
  logic            cv_q, fe_q, byte_ok, err;

  ps2_filtro #(.FILTER_LEN(FILTER_LEN)) u_filtro (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_i  (ps2_clk),
    .fall_o (fall)
  );

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    byte_ok  = 1'b0;
    err      = 1'b0;
    if (fall) begin
      wd_d = '0;
    end else if (state_q != IDLE) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = '0;
    end

    if (state_q != IDLE && !fall && wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
      err     = 1'b1;
      state_d = IDLE;
      wd_d    = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dsync_q[1]) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end else begin
            err = 1'b1;
          end
        end
        DATA: begin
          shreg_d  = {dsync_q[1], shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dsync_q[1];
          state_d = STOP;
        end
        STOP: begin
          if (dsync_q[1] && (^{shreg_q, par_q})) byte_ok = 1'b1;
          else                                   err     = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Code layer reacts in the same cycle the byte is accepted so enable and code_valid align.
  always_comb begin
    enable_d = enable_q;
    brk_d    = brk_q;
    ext_d    = ext_q;
    scan_d   = scan_q;
    key      = key_onehot(shreg_q);
    if (byte_ok) begin
      scan_d = shreg_q;
      if (shreg_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (shreg_q == SC_BRK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        if (key != '0 && (key & enable_q) == key) enable_d = '0;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (ext_q) begin
        ext_d = 1'b0;
      end else if (key != '0) begin
        enable_d = key;
      end
    end else if (err) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsync_q  <= 2'b00;
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      wd_q     <= '0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      enable_q <= '0;
      scan_q   <= '0;
      cv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      dsync_q  <= {dsync_q[0], ps2_data};
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      wd_q     <= wd_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      enable_q <= enable_d;
      scan_q   <= scan_d;
      cv_q     <= byte_ok;
      fe_q     <= err;
    end
  end

  assign enable     = enable_q;
  assign scan_code  = scan_q;
  assign code_valid = cv_q;
  assign frame_err  = fe_q;

endmodule

// File: tb/tb_receptor_ps2_teclado.sv
// tb/tb_receptor_ps2_teclado.sv - directed self-checking bench for receptor_ps2_teclado
module tb_receptor_ps2_teclado;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [4:0] enable;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int fe_cyc = 0;
  int last_fall_cyc = 0;

  receptor_ps2_teclado #(.FILTER_LEN(4), .TIMEOUT_CYC(2000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .enable     (enable),
    .scan_code  (scan_code),
    .code_valid (code_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (code_valid === 1'b1) cv_cnt++;
    if (frame_err === 1'b1) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
  end

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input logic flip_par, input logic stop_v, input int n);
    logic [10:0] fr;
    fr = {stop_v, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < n; i++) ps2_bit(fr[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b0, 1'b1, 11);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (enable !== 5'd0) begin bad++; $display("FAIL reset_enable got=%b exp=00000", enable); end
    total++; if (scan_code !== 8'h00) begin bad++; $display("FAIL reset_scan got=%h exp=00", scan_code); end
    total++; if (code_valid !== 1'b0) begin bad++; $display("FAIL reset_cv got=%b exp=0", code_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b exp=0", frame_err); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single;
    int cv0, fe0;
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_byte(8'h1C);
    total++; if (cv_cnt - cv0 !== 1) begin bad++; $display("FAIL single_cv got=%0d exp=1", cv_cnt - cv0); end
    total++; if (fe_cnt - fe0 !== 0) begin bad++; $display("FAIL single_fe got=%0d exp=0", fe_cnt - fe0); end
    total++; if (scan_code !== 8'h1C) begin bad++; $display("FAIL single_scan got=%h exp=1c", scan_code); end
    total++; if (enable !== 5'b10000) begin bad++; $display("FAIL single_enable got=%b exp=10000", enable); end
  endtask

  task automatic test_make_break;
    int cv0;
    cv0 = cv_cnt;
    send_byte(8'h16);
    total++; if (enable !== 5'b00001) begin bad++; $display("FAIL mb_16 got=%b exp=00001", enable); end
    send_byte(8'h1E);
    total++; if (enable !== 5'b00010) begin bad++; $display("FAIL mb_1e got=%b exp=00010", enable); end
    send_byte(8'h1E);
    total++; if (enable !== 5'b00010) begin bad++; $display("FAIL mb_typematic got=%b exp=00010", enable); end
    send_byte(8'hF0);
    total++; if (enable !== 5'b00010) begin bad++; $display("FAIL mb_f0 got=%b exp=00010", enable); end
    send_byte(8'h1E);
    total++; if (enable !== 5'b00000) begin bad++; $display("FAIL mb_break got=%b exp=00000", enable); end
    total++; if (cv_cnt - cv0 !== 5) begin bad++; $display("FAIL mb_cv got=%0d exp=5", cv_cnt - cv0); end
  endtask

  task automatic test_break_other;
    send_byte(8'h26);
    total++; if (enable !== 5'b00100) begin bad++; $display("FAIL bo_26 got=%b exp=00100", enable); end
    send_byte(8'hF0);
    send_byte(8'h16);
    total++; if (enable !== 5'b00100) begin bad++; $display("FAIL bo_break16 got=%b exp=00100", enable); end
    send_byte(8'h25);
    total++; if (enable !== 5'b01000) begin bad++; $display("FAIL bo_25 got=%b exp=01000", enable); end
  endtask

  task automatic test_errors;
    int cv0, fe0;
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_bits(8'h1C, 1'b1, 1'b1, 11);
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL par_fe got=%0d exp=1", fe_cnt - fe0); end
    total++; if (cv_cnt - cv0 !== 0) begin bad++; $display("FAIL par_cv got=%0d exp=0", cv_cnt - cv0); end
    total++; if (enable !== 5'b01000) begin bad++; $display("FAIL par_enable got=%b exp=01000", enable); end
    fe0 = fe_cnt;
    send_bits(8'h25, 1'b0, 1'b0, 11);
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL stop_fe got=%0d exp=1", fe_cnt - fe0); end
    total++; if (cv_cnt - cv0 !== 0) begin bad++; $display("FAIL stop_cv got=%0d exp=0", cv_cnt - cv0); end
    fe0 = fe_cnt;
    ps2_bit(1'b1);
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL start_fe got=%0d exp=1", fe_cnt - fe0); end
    total++; if (scan_code !== 8'h25) begin bad++; $display("FAIL err_scan got=%h exp=25", scan_code); end
  endtask

  task automatic test_timeout;
    int fe0, t0;
    fe0 = fe_cnt;
    send_bits(8'h16, 1'b0, 1'b1, 4);
    t0 = last_fall_cyc;
    repeat (2500) @(negedge clk);
    total++; if (fe_cnt - fe0 !== 1) begin bad++; $display("FAIL to_fe got=%0d exp=1", fe_cnt - fe0); end
    total++; if (fe_cyc < t0 + 2000 || fe_cyc > t0 + 2020) begin bad++; $display("FAIL to_when got=%0d exp=%0d..%0d", fe_cyc, t0 + 2000, t0 + 2020); end
    send_byte(8'h16);
    total++; if (enable !== 5'b00001) begin bad++; $display("FAIL to_next got=%b exp=00001", enable); end
  endtask

  task automatic test_ext;
    send_byte(8'hF0);
    send_byte(8'h16);
    total++; if (enable !== 5'b00000) begin bad++; $display("FAIL ext_clear got=%b exp=00000", enable); end
    send_byte(8'hE0);
    send_byte(8'h1C);
    total++; if (enable !== 5'b00000) begin bad++; $display("FAIL ext_enter got=%b exp=00000", enable); end
    total++; if (scan_code !== 8'h1C) begin bad++; $display("FAIL ext_scan got=%h exp=1c", scan_code); end
    send_byte(8'h1E);
    total++; if (enable !== 5'b00010) begin bad++; $display("FAIL ext_after got=%b exp=00010", enable); end
  endtask

  task automatic test_reset_midframe;
    int fe0, cv0;
    send_byte(8'h25);
    total++; if (enable !== 5'b01000) begin bad++; $display("FAIL rm_pre got=%b exp=01000", enable); end
    send_bits(8'h16, 1'b0, 1'b1, 5);
    #2 rst_n = 1'b0;
    #1;
    total++; if (enable !== 5'd0) begin bad++; $display("FAIL rm_enable got=%b exp=00000", enable); end
    total++; if (scan_code !== 8'h00) begin bad++; $display("FAIL rm_scan got=%h exp=00", scan_code); end
    total++; if (code_valid !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL rm_pulses got=%b%b exp=00", code_valid, frame_err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    fe0 = fe_cnt; cv0 = cv_cnt;
    send_byte(8'h16);
    total++; if (enable !== 5'b00001) begin bad++; $display("FAIL rm_next got=%b exp=00001", enable); end
    total++; if (scan_code !== 8'h16) begin bad++; $display("FAIL rm_next_scan got=%h exp=16", scan_code); end
    total++; if (fe_cnt - fe0 !== 0 || cv_cnt - cv0 !== 1) begin bad++; $display("FAIL rm_counts got=fe%0d cv%0d exp=fe0 cv1", fe_cnt - fe0, cv_cnt - cv0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_make_break();
    test_break_other();
    test_errors();
    test_timeout();
    test_ext();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
